// File: rtl/ldst_unit.sv
`default_nettype none
// ============================================================================
// Module      : ldst_unit
// Description : Multi-cycle load/store unit for the 8-bit accumulator core.
//               Runs a req/ack handshake with data memory, stalls the core
//               while the access is outstanding and returns load data as a
//               one-cycle register-file write-back pulse.
//               Optional feature macro: LDST_TIMEOUT_EN (ack timeout + err).
// Revision    : 1.0 - initial release
// ============================================================================
module ldst_unit #(
  parameter int W   = 8,
  parameter int TMO = 15
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic         is_store,
  input  logic [W-1:0] addr_in,
  input  logic [W-1:0] wdata_in,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         stall,
  output logic         wb_en,
  output logic [W-1:0] wb_data,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   timeout;

  // A command is taken in IDLE, or in WB so back-to-back loads do not lose a cycle
  assign accept = start && ((state == IDLE) || (state == WB));

  assign mem_req = (state == REQ);
  assign wb_en   = (state == WB);
  // Combinational so the decode cycle that raises start is itself held
  assign stall   = start | mem_req;

`ifdef LDST_TIMEOUT_EN
  logic [3:0] cnt;

  // The access gives up when the count of ack-less REQ cycles would reach TMO
  assign timeout = (state == REQ) && !mem_ack && (cnt == 4'(TMO - 1));

  // Count REQ cycles without ack; restart on every accepted command
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == REQ) && !mem_ack) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Sticky error flag, only reset clears it
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an ack (or timeout) ends the access, loads detour via WB
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack || timeout) begin
          state_nxt = mem_we ? IDLE : WB;
        end
      end
      WB: begin
        state_nxt = start ? REQ : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command capture; held stable until the next accepted command
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (accept) begin
      mem_addr  <= addr_in;
      mem_wdata <= wdata_in;
      mem_we    <= is_store;
    end
  end

  // Load return data; a timed-out load writes back all ones
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wb_data <= '0;
    end else if ((state == REQ) && !mem_we) begin
      if (mem_ack) begin
        wb_data <= mem_rdata;
      end else if (timeout) begin
        wb_data <= '1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ldst_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldst_unit
// Description : Self-checking bench for ldst_unit. Load results are pushed to
//               a queue when the command is driven and popped on wb_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldst_unit;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [7:0] addr_in = '0;
  logic [7:0] wdata_in = '0;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       stall;
  logic       wb_en;
  logic [7:0] wb_data;
  logic       err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_wb = 0;
  logic [7:0] exp_q[$];

  ldst_unit #(.W(8), .TMO(15)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the active edge; sample point: falling edge
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Scoreboard: every write-back pulse must match the oldest queued load result
  always @(negedge CLK) begin
    if (wb_en === 1'b1) begin
      n_wb++;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_en), 32'd0);
      end else begin
        check("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int cyc;
    int wb_before;

    // ---------------- reset values ----------------
    #2;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_wb_en", 32'(wb_en), 0);
    check("rst_err", 32'(err), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wb_data", 32'(wb_data), 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;

    // ---------------- load, ack on first REQ cycle ----------------
    next_cycle();
    start = 1'b1; is_store = 1'b0; addr_in = 8'h3C; wdata_in = 8'h00;
    sample();
    check("ld_stall_c0", 32'(stall), 1);
    next_cycle();
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hA5; exp_q.push_back(8'hA5);
    sample();
    check("ld_req_c1", 32'(mem_req), 1);
    check("ld_addr", 32'(mem_addr), 32'h3C);
    check("ld_we", 32'(mem_we), 0);
    check("ld_stall_c1", 32'(stall), 1);
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("ld_wb_c2", 32'(wb_en), 1);
    check("ld_stall_c2", 32'(stall), 0);
    check("ld_req_c2", 32'(mem_req), 0);
    next_cycle();
    sample();
    check("ld_wb_c3", 32'(wb_en), 0);

    // ---------------- store, ack delayed 4 cycles ----------------
    next_cycle();
    start = 1'b1; is_store = 1'b1; addr_in = 8'h10; wdata_in = 8'h7E;
    sample();
    check("st_stall_c0", 32'(stall), 1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      start = 1'b0; addr_in = 8'hEE; wdata_in = 8'hEE;
      mem_ack = (c == 5);
      sample();
      check("st_req", 32'(mem_req), 1);
      check("st_we", 32'(mem_we), 1);
      check("st_wdata", 32'(mem_wdata), 32'h7E);
      check("st_addr", 32'(mem_addr), 32'h10);
    end
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("st_stall_c6", 32'(stall), 0);
    check("st_req_c6", 32'(mem_req), 0);
    check("st_wb_c6", 32'(wb_en), 0);

    // ---------------- back-to-back loads ----------------
    wb_before = n_wb;
    next_cycle();
    start = 1'b1; is_store = 1'b0; addr_in = 8'h21;
    next_cycle();
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h11; exp_q.push_back(8'h11);
    next_cycle();
    // WB cycle of the first load: issue the second one
    mem_ack = 1'b0; start = 1'b1; addr_in = 8'h22;
    sample();
    check("b2b_wb1", 32'(wb_en), 1);
    check("b2b_stall_wb", 32'(stall), 1);
    next_cycle();
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h5C; exp_q.push_back(8'h5C);
    sample();
    check("b2b_req2", 32'(mem_req), 1);
    check("b2b_addr2", 32'(mem_addr), 32'h22);
    next_cycle();
    mem_ack = 1'b0;
    next_cycle();
    sample();
    check("b2b_two_pulses", 32'(n_wb - wb_before), 2);

    // ---------------- spurious ack in IDLE, start while in REQ ----------------
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 8'hDD;
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("spur_req", 32'(mem_req), 0);
    check("spur_stall", 32'(stall), 0);
    check("spur_wb", 32'(wb_en), 0);
    next_cycle();
    start = 1'b1; is_store = 1'b0; addr_in = 8'h40;
    next_cycle();
    start = 1'b1; is_store = 1'b1; addr_in = 8'h99; wdata_in = 8'h33;
    next_cycle();
    start = 1'b0;
    sample();
    check("spur_in_req", 32'(mem_req), 1);
    check("spur_addr_kept", 32'(mem_addr), 32'h40);
    check("spur_we_kept", 32'(mem_we), 0);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 8'h5A; exp_q.push_back(8'h5A);
    next_cycle();
    mem_ack = 1'b0;
    next_cycle();

    // ---------------- asynchronous reset mid-REQ ----------------
    wb_before = n_wb;
    next_cycle();
    start = 1'b1; is_store = 1'b0; addr_in = 8'h77;
    next_cycle();
    start = 1'b0;
    sample();
    check("ar_req_before", 32'(mem_req), 1);
    #2 reset = 1'b1;
    #1;
    check("ar_req_async", 32'(mem_req), 0);
    check("ar_stall_async", 32'(stall), 0);
    check("ar_err", 32'(err), 0);
    check("ar_addr", 32'(mem_addr), 0);
    // a late ack must not produce a write-back once reset is released
    mem_ack = 1'b1; mem_rdata = 8'hBB;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    mem_ack = 1'b0;
    repeat (3) next_cycle();
    check("ar_no_wb", 32'(n_wb - wb_before), 0);

`ifdef LDST_TIMEOUT_EN
    // ---------------- timeout on a load with no ack ----------------
    next_cycle();
    start = 1'b1; is_store = 1'b0; addr_in = 8'h05;
    exp_q.push_back(8'hFF);
    next_cycle();
    start = 1'b0;
    cyc = 0;
    sample();
    while (mem_req === 1'b1 && cyc < 40) begin
      cyc++;
      sample();
    end
    check("to_req_cycles", 32'(cyc), 15);
    check("to_err", 32'(err), 1);
    check("to_wb_en", 32'(wb_en), 1);
    // err stays set across a later successful store
    next_cycle();
    start = 1'b1; is_store = 1'b1; addr_in = 8'h06; wdata_in = 8'h01;
    next_cycle();
    start = 1'b0; mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("to_err_sticky", 32'(err), 1);
    next_cycle();
    reset = 1'b1;
    #1;
    check("to_err_cleared", 32'(err), 0);
    next_cycle();
    reset = 1'b0;
`else
    cyc = 0;
    check("no_to_err", 32'(err), 32'(cyc));
`endif

    repeat (2) next_cycle();
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "time bound exceeded");
  end

endmodule
`default_nettype wire
